// File: rtl/fpga_cfg_loader.sv
// Byte-serial configuration loader: assembles select vectors in shadow registers and
// publishes them atomically to the fabric on a COMMIT command.
module fpga_cfg_loader #(
  parameter int unsigned BRB_W = 900,
  parameter int unsigned BSB_W = 1728,
  parameter int unsigned LB_W  = 80,
  parameter int unsigned IO_W  = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BRB_W-1:0] brbselect,
  output logic [BSB_W-1:0] bsbselect,
  output logic [LB_W-1:0]  lbselect,
  output logic [IO_W-1:0]  leftioselect,
  output logic [IO_W-1:0]  rightioselect,
  output logic [IO_W-1:0]  topioselect,
  output logic [IO_W-1:0]  bottomioselect,
  output logic             cfg_valid,
  output logic             cfg_done,
  output logic             busy,
  output logic             err
);

  localparam logic [1:0] StCmd    = 2'd0;
  localparam logic [1:0] StLoad   = 2'd1;
  localparam logic [1:0] StCommit = 2'd2;
  localparam logic [1:0] StErr    = 2'd3;

  localparam int unsigned BRB_NB = (BRB_W + 7) / 8;
  localparam int unsigned BSB_NB = (BSB_W + 7) / 8;
  localparam int unsigned LB_NB  = (LB_W + 7) / 8;
  localparam int unsigned IO_NB  = (IO_W + 7) / 8;

  logic [1:0] state_q, state_d;
  logic [2:0] tgt_q, tgt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] last_cnt;
  logic       xfer;
  logic       ld;

  logic [BRB_W-1:0] brb_sh_q;
  logic [BSB_W-1:0] bsb_sh_q;
  logic [LB_W-1:0]  lb_sh_q;
  logic [IO_W-1:0]  left_sh_q, right_sh_q, top_sh_q, bottom_sh_q;

  logic cfg_valid_q, cfg_done_q;

  assign in_ready  = (state_q == StCmd) || (state_q == StLoad);
  assign busy      = (state_q == StLoad);
  assign err       = (state_q == StErr);
  assign xfer      = in_valid & in_ready;
  assign ld        = xfer && (state_q == StLoad);
  assign cfg_valid = cfg_valid_q;
  assign cfg_done  = cfg_done_q;

  always_comb begin
    case (tgt_q)
      3'd0:    last_cnt = 8'(BRB_NB - 1);
      3'd1:    last_cnt = 8'(BSB_NB - 1);
      3'd2:    last_cnt = 8'(LB_NB - 1);
      default: last_cnt = 8'(IO_NB - 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    case (state_q)
      StCmd: begin
        if (xfer) begin
          if (in_data[7:3] != 5'd0) begin
            state_d = StErr;
          end else if (in_data[2:0] == 3'd7) begin
            state_d = StCommit;
          end else begin
            tgt_d   = in_data[2:0];
            cnt_d   = 8'd0;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (xfer) begin
          if (cnt_q == last_cnt) state_d = StCmd;
          else                   cnt_d   = cnt_q + 8'd1;
        end
      end
      StCommit: state_d = StCmd;
      default:  state_d = StErr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StCmd;
      tgt_q       <= 3'd0;
      cnt_q       <= 8'd0;
      cfg_valid_q <= 1'b0;
      cfg_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      cfg_done_q <= (state_q == StCommit);
      if (state_q == StCommit) cfg_valid_q <= 1'b1;
    end
  end

  // Byte cnt lands on bits [8*cnt +: 8]; bits past the section width simply have no home.
  always_ff @(posedge clk) begin
    if (rst) begin
      brb_sh_q    <= '0;
      bsb_sh_q    <= '0;
      lb_sh_q     <= '0;
      left_sh_q   <= '0;
      right_sh_q  <= '0;
      top_sh_q    <= '0;
      bottom_sh_q <= '0;
    end else if (ld) begin
      for (int unsigned i = 0; i < BRB_W; i++)
        if (tgt_q == 3'd0 && cnt_q == 8'(i / 8)) brb_sh_q[i] <= in_data[3'(i % 8)];
      for (int unsigned i = 0; i < BSB_W; i++)
        if (tgt_q == 3'd1 && cnt_q == 8'(i / 8)) bsb_sh_q[i] <= in_data[3'(i % 8)];
      for (int unsigned i = 0; i < LB_W; i++)
        if (tgt_q == 3'd2 && cnt_q == 8'(i / 8)) lb_sh_q[i] <= in_data[3'(i % 8)];
      for (int unsigned i = 0; i < IO_W; i++) begin
        if (tgt_q == 3'd3 && cnt_q == 8'(i / 8)) left_sh_q[i]   <= in_data[3'(i % 8)];
        if (tgt_q == 3'd4 && cnt_q == 8'(i / 8)) right_sh_q[i]  <= in_data[3'(i % 8)];
        if (tgt_q == 3'd5 && cnt_q == 8'(i / 8)) top_sh_q[i]    <= in_data[3'(i % 8)];
        if (tgt_q == 3'd6 && cnt_q == 8'(i / 8)) bottom_sh_q[i] <= in_data[3'(i % 8)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      brbselect      <= '0;
      bsbselect      <= '0;
      lbselect       <= '0;
      leftioselect   <= '0;
      rightioselect  <= '0;
      topioselect    <= '0;
      bottomioselect <= '0;
    end else if (state_q == StCommit) begin
      brbselect      <= brb_sh_q;
      bsbselect      <= bsb_sh_q;
      lbselect       <= lb_sh_q;
      leftioselect   <= left_sh_q;
      rightioselect  <= right_sh_q;
      topioselect    <= top_sh_q;
      bottomioselect <= bottom_sh_q;
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed self-checking bench for fpga_cfg_loader.
module tb_fpga_cfg_loader;

  localparam int unsigned BRB_W = 900;
  localparam int unsigned BSB_W = 1728;
  localparam int unsigned LB_W  = 80;
  localparam int unsigned IO_W  = 30;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [BRB_W-1:0] brbselect;
  logic [BSB_W-1:0] bsbselect;
  logic [LB_W-1:0]  lbselect;
  logic [IO_W-1:0]  leftioselect, rightioselect, topioselect, bottomioselect;
  logic             cfg_valid, cfg_done, busy, err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] mem [7][216];
  int nbs [7] = '{113, 216, 10, 4, 4, 4, 4};

  logic [BRB_W-1:0] exp_brb;
  logic [BSB_W-1:0] exp_bsb;
  logic [LB_W-1:0]  exp_lb;
  logic [IO_W-1:0]  exp_io [4];

  always #5 clk = ~clk;

  fpga_cfg_loader #(
    .BRB_W(BRB_W), .BSB_W(BSB_W), .LB_W(LB_W), .IO_W(IO_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .brbselect      (brbselect),
    .bsbselect      (bsbselect),
    .lbselect       (lbselect),
    .leftioselect   (leftioselect),
    .rightioselect  (rightioselect),
    .topioselect    (topioselect),
    .bottomioselect (bottomioselect),
    .cfg_valid      (cfg_valid),
    .cfg_done       (cfg_done),
    .busy           (busy),
    .err            (err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents a byte, waits (bounded) for in_ready, returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("send_timeout", 128'(in_ready), 128'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // COMMIT then step to the cycle where the new configuration is visible.
  task automatic commit();
    send_byte(8'h07);
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst      = 1'b1;
    idle(2);
    rst = 1'b0;

    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_cfg_valid", 128'(cfg_valid), 128'd0);
    check("rst_cfg_done", 128'(cfg_done), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_brb_zero", 128'(brbselect == '0), 128'd1);

    // 1: bottom io = 1
    send_byte(8'h06);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h07);
    check("t1_commit_in_ready", 128'(in_ready), 128'd0);
    check("t1_bottom_before", 128'(bottomioselect), 128'd0);
    check("t1_done_before", 128'(cfg_done), 128'd0);
    @(posedge clk);
    #1;
    check("t1_bottom", 128'(bottomioselect), 128'h1);
    check("t1_done", 128'(cfg_done), 128'd1);
    check("t1_valid", 128'(cfg_valid), 128'd1);
    check("t1_lb", 128'(lbselect), 128'd0);
    check("t1_left", 128'(leftioselect), 128'd0);
    check("t1_bsb_zero", 128'(bsbselect == '0), 128'd1);
    idle(1);
    check("t1_done_pulse", 128'(cfg_done), 128'd0);

    // 2: brb with first and last byte set
    send_byte(8'h00);
    for (int k = 0; k < 113; k++) begin
      if (k == 1) check("t2_busy", 128'(busy), 128'd1);
      send_byte(k == 0 ? 8'h20 : (k == 112 ? 8'hFF : 8'h00));
    end
    check("t2_busy_end", 128'(busy), 128'd0);
    check("t2_brb_before", 128'(brbselect == '0), 128'd1);
    commit();
    exp_brb = '0;
    exp_brb[5] = 1'b1;
    exp_brb[899:896] = 4'hF;
    check("t2_brb_full", 128'(brbselect == exp_brb), 128'd1);
    check("t2_brb_top", 128'(brbselect[899:892]), 128'hF0);
    check("t2_brb_low", 128'(brbselect[127:0]), 128'h20);
    check("t2_bottom_kept", 128'(bottomioselect), 128'h1);

    // 3: lb load without commit, then commit
    send_byte(8'h02);
    for (int k = 0; k < 10; k++) begin
      check("t3_busy", 128'(busy), 128'd1);
      send_byte(8'hA5);
    end
    check("t3_lb_before", 128'(lbselect), 128'd0);
    commit();
    check("t3_lb", 128'(lbselect), 128'hA5A5_A5A5_A5A5_A5A5_A5A5);

    // 4: bad command
    send_byte(8'h28);
    check("t4_err", 128'(err), 128'd1);
    check("t4_in_ready", 128'(in_ready), 128'd0);
    in_valid = 1'b1;
    in_data  = 8'h07;
    idle(3);
    in_data  = 8'h02;
    idle(2);
    in_valid = 1'b0;
    check("t4_err_sticky", 128'(err), 128'd1);
    check("t4_no_done", 128'(cfg_done), 128'd0);
    check("t4_lb_frozen", 128'(lbselect), 128'hA5A5_A5A5_A5A5_A5A5_A5A5);
    check("t4_bottom_frozen", 128'(bottomioselect), 128'h1);
    do_reset();
    check("t4_err_clr", 128'(err), 128'd0);
    check("t4_in_ready_clr", 128'(in_ready), 128'd1);
    check("t4_lb_clr", 128'(lbselect), 128'd0);
    check("t4_brb_clr", 128'(brbselect == '0), 128'd1);
    check("t4_valid_clr", 128'(cfg_valid), 128'd0);

    // 5: reset mid-load of bsb
    send_byte(8'h01);
    for (int k = 0; k < 100; k++) send_byte(8'hFF);
    check("t5_busy_mid", 128'(busy), 128'd1);
    do_reset();
    check("t5_busy_rst", 128'(busy), 128'd0);
    commit();
    check("t5_bsb_zero", 128'(bsbselect == '0), 128'd1);
    check("t5_valid", 128'(cfg_valid), 128'd1);

    // 6: full random load with random idle gaps
    for (int s = 0; s < 7; s++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      send_byte(8'(s));
      for (int k = 0; k < nbs[s]; k++) begin
        mem[s][k] = 8'($urandom);
        if ($urandom_range(0, 1) == 1) idle(1);
        send_byte(mem[s][k]);
      end
    end
    for (int i = 0; i < BRB_W; i++) exp_brb[i] = mem[0][i / 8][i % 8];
    for (int i = 0; i < BSB_W; i++) exp_bsb[i] = mem[1][i / 8][i % 8];
    for (int i = 0; i < LB_W; i++)  exp_lb[i]  = mem[2][i / 8][i % 8];
    for (int s = 0; s < 4; s++)
      for (int i = 0; i < IO_W; i++) exp_io[s][i] = mem[3 + s][i / 8][i % 8];
    check("t6_bsb_before", 128'(bsbselect == '0), 128'd1);
    commit();
    check("t6_brb", 128'(brbselect == exp_brb), 128'd1);
    check("t6_bsb", 128'(bsbselect == exp_bsb), 128'd1);
    check("t6_lb", 128'(lbselect), 128'(exp_lb));
    check("t6_left", 128'(leftioselect), 128'(exp_io[0]));
    check("t6_right", 128'(rightioselect), 128'(exp_io[1]));
    check("t6_top", 128'(topioselect), 128'(exp_io[2]));
    check("t6_bottom", 128'(bottomioselect), 128'(exp_io[3]));
    check("t6_done", 128'(cfg_done), 128'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
